// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC block: default field widths (shared with the
// TDC core so the measured-interval width matches the generated interval) and
// the pulse-pair generator state encoding.
package tdc_pkg;

  localparam int unsigned TDC_DLY_W = 8;
  localparam int unsigned TDC_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DELAY,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } tdc_gen_state_t;

endpackage

// File: rtl/tdc_dly_counter.sv
// Loadable down-counter with terminal-count flag. Used by the pulse-pair
// generator to time both the start-to-stop delay and the inter-pair gap.
// Ports:
//   clk_i      - clock
//   rst_i      - asynchronous active-high reset (count cleared)
//   load_i     - load load_val_i on the next edge (priority over en_i)
//   load_val_i - value to load
//   en_i       - decrement on the next edge; holds at zero
//   tc_o       - count is zero
module tdc_dly_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/tdc_pulse_gen.sv
// Programmable start/stop pulse-pair generator feeding the TDC start/stop
// inputs for self-test and calibration. After a configuration handshake it
// emits R+1 pairs: start_o, then stop_o D cycles later, then G idle cycles
// before the next start_o. All outputs are decoded from registered state.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   cfg_valid/cfg_ready - configuration handshake (ready only when idle)
//   cfg_delay           - start-to-stop interval D (cycles)
//   cfg_gap             - idle cycles G between a stop and the next start
//   cfg_repeat          - R; R+1 pairs are generated
//   abort               - synchronous cancel of a running sequence
//   start_o, stop_o     - one-cycle start/stop pulses
//   busy                - generator not idle
//   done                - one-cycle pulse after the last stop (not on abort)
//   seq_idx             - index of the pair in progress
module tdc_pulse_gen
  import tdc_pkg::*;
#(
  parameter int unsigned DLY_W = TDC_DLY_W,
  parameter int unsigned CNT_W = TDC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [DLY_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_repeat,
  input  logic             abort,
  output logic             start_o,
  output logic             stop_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] seq_idx
);

  tdc_gen_state_t   state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [DLY_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] rep_q, rep_d;

  logic             cnt_load;
  logic [DLY_W-1:0] cnt_val;
  logic             cnt_en;
  logic             cnt_tc;
  logic             pair_end;

  tdc_dly_counter #(
    .W (DLY_W)
  ) u_dly_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .tc_o       (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dly_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      gap_q   <= gap_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dly_d    = dly_q;
    gap_d    = gap_q;
    rep_d    = rep_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    pair_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid && !abort) begin
          state_d = ST_START;
          dly_d   = cfg_delay;
          gap_d   = cfg_gap;
          rep_d   = cfg_repeat;
          idx_d   = '0;
        end
      end
      ST_START: begin
        // D==0 emits stop in the START cycle, so START also ends the pair.
        if (dly_q == '0) begin
          pair_end = 1'b1;
        end else if (dly_q == DLY_W'(1)) begin
          state_d = ST_STOP;
        end else begin
          // DELAY lasts D-1 cycles: it exits when the counter reads zero.
          state_d  = ST_DELAY;
          cnt_load = 1'b1;
          cnt_val  = dly_q - DLY_W'(2);
        end
      end
      ST_DELAY: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        pair_end = 1'b1;
      end
      ST_GAP: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = ST_START;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    if (pair_end) begin
      if (idx_q == rep_q) begin
        state_d = ST_DONE;
      end else begin
        idx_d = idx_q + CNT_W'(1);
        if (gap_q != '0) begin
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = gap_q - DLY_W'(1);
        end else begin
          state_d = ST_START;
        end
      end
    end

    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      cnt_load = 1'b0;
    end
  end

  always_comb begin
    cfg_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    start_o   = (state_q == ST_START);
    stop_o    = (state_q == ST_STOP) || ((state_q == ST_START) && (dly_q == '0));
    done      = (state_q == ST_DONE);
    seq_idx   = idx_q;
  end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
module tb_tdc_pulse_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef struct {
    int kind;  // 0 start, 1 stop, 2 done
    int cyc;
    int idx;   // -1: not checked
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] cfg_delay = '0;
  logic [DW-1:0] cfg_gap = '0;
  logic [CW-1:0] cfg_repeat = '0;
  logic          abort = 1'b0;
  logic          start_o, stop_o, busy, done;
  logic [CW-1:0] seq_idx;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  ev_t  exp_q[$];

  tdc_pulse_gen #(
    .DLY_W (DW),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_delay  (cfg_delay),
    .cfg_gap    (cfg_gap),
    .cfg_repeat (cfg_repeat),
    .abort      (abort),
    .start_o    (start_o),
    .stop_o     (stop_o),
    .busy       (busy),
    .done       (done),
    .seq_idx    (seq_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic push_ev(input int kind, input int c, input int idx);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  // Expected pulse timeline from the timing rules; returns the done cycle.
  task automatic push_seq(input int t0, input int d, input int g, input int r,
                          output int done_cyc);
    int t;
    t = t0;
    done_cyc = 0;
    for (int p = 0; p <= r; p++) begin
      push_ev(0, t, p);
      push_ev(1, t + d, p);
      if (p == r) begin
        done_cyc = t + d + 1;
        push_ev(2, done_cyc, -1);
      end else begin
        t = t + d + g + 1;
      end
    end
  endtask

  task automatic match(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("spurious_pulse_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.cyc);
      if (e.idx >= 0) chk("pulse_seq_idx", int'(seq_idx), e.idx);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (start_o) match(0);
      if (stop_o)  match(1);
      if (done)    match(2);
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Offers a configuration; t0 is the cycle in which START is expected.
  task automatic offer(input int d, input int g, input int r, output int t0);
    @(negedge clk);
    chk("cfg_ready_before_offer", int'(cfg_ready), 1);
    cfg_delay  = DW'(d);
    cfg_gap    = DW'(g);
    cfg_repeat = CW'(r);
    cfg_valid  = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic run_seq(input string tag, input int d, input int g, input int r);
    int t0, dc;
    offer(d, g, r, t0);
    push_seq(t0, d, g, r, dc);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk({tag, "_busy_t0"}, int'(busy), 1);
    wait_cyc(dc);
    chk({tag, "_ready_at_done"}, int'(cfg_ready), 0);
    wait_cyc(dc + 1);
    chk({tag, "_ready_after"}, int'(cfg_ready), 1);
    chk({tag, "_busy_after"}, int'(busy), 0);
    wait_cyc(dc + 4);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int t0, dc;

    // Reset state
    #12;
    chk("rst_start", int'(start_o), 0);
    chk("rst_stop", int'(stop_o), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_seq_idx", int'(seq_idx), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_seq("d5g2r0", 5, 2, 0);
    run_seq("d3g0r2", 3, 0, 2);
    run_seq("d0g1r1", 0, 1, 1);
    run_seq("d1g0r15", 1, 0, 15);
    run_seq("d2g3r1", 2, 3, 1);
    run_seq("d255g255r1", 255, 255, 1);

    // Abort mid-delay: only the first start appears
    offer(10, 0, 3, t0);
    push_ev(0, t0, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_cyc(t0 + 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(cfg_ready), 1);
    chk("abort_seq_idx", int'(seq_idx), 0);
    wait_cyc(t0 + 20);
    chk("abort_queue_drained", exp_q.size(), 0);

    // Abort in IDLE together with a valid offer: not accepted
    @(negedge clk);
    cfg_delay = DW'(4);
    cfg_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    abort = 1'b0;
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_idle_ready", int'(cfg_ready), 1);
    repeat (3) @(negedge clk);

    // cfg_valid held with a new D while busy
    offer(4, 0, 0, t0);
    push_seq(t0, 4, 0, 0, dc);
    push_seq(t0 + 7, 7, 0, 0, dc);
    @(negedge clk);
    cfg_delay = DW'(7);
    wait_cyc(t0 + 6);
    chk("hold_ready_idle", int'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("hold_second_start", int'(start_o), 1);
    wait_cyc(dc + 4);
    chk("hold_queue_drained", exp_q.size(), 0);

    // Asynchronous reset mid-sequence
    offer(6, 0, 0, t0);
    push_ev(0, t0, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_cyc(t0 + 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(cfg_ready), 1);
    chk("arst_start", int'(start_o), 0);
    chk("arst_stop", int'(stop_o), 0);
    chk("arst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(t0 + 20);
    chk("arst_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tdc_pulse_gen.md
Name: tdc_pulse_gen

Overview:
- Programmable start/stop pulse-pair generator. It is the stimulus end of the time-to-digital converter: it produces a start edge, then a stop edge a programmed number of clock cycles later, repeated a programmed number of times.
- Drives the TDC start/stop inputs for on-chip self-test and calibration.
- Sits beside the TDC core inside tt_um_topTDC. Configuration comes from the ui_in/uio_in register path.

Parameters:
- DLY_W, 8, width of the start-to-stop delay and inter-pair gap fields (cycles).
- CNT_W, 4, width of the repeat count and the pair-index output.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  configuration offered.
- cfg_ready  output  1  generator idle and able to accept configuration.
- cfg_delay  input  DLY_W  start-to-stop interval D, in cycles.
- cfg_gap  input  DLY_W  idle cycles G between one stop and the next start.
- cfg_repeat  input  CNT_W  R; number of pairs generated is R+1.
- abort  input  1  synchronous cancel of a running sequence.
- start_o  output  1  start pulse, one cycle wide.
- stop_o  output  1  stop pulse, one cycle wide.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the final stop of an uncancelled sequence.
- seq_idx  output  CNT_W  index of the pair currently in progress, counting from 0.

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=IDLE; start_o, stop_o, done and busy = 0; seq_idx=0; cfg_ready=1.
  - All internal counters and latched configuration are cleared.
- FSM states: IDLE, START, DELAY, STOP, GAP, DONE.
  - All outputs are Moore outputs decoded from registered state and registered latched fields; there are no combinational paths from inputs.
- cfg_ready = (state==IDLE).
  - Handshake completes on the edge where cfg_valid && cfg_ready; D, G and R are latched at that edge.
  - The latched values do not change until the next handshake. cfg_* is ignored outside IDLE.
- IDLE -> START on handshake. Let the cycle after the handshake edge be t0.
- START (one cycle):
  - start_o=1 and seq_idx = current pair index.
  - D==0: stop_o=1 in the same cycle (zero interval); the next state is GAP or DONE, as after STOP.
  - D==1: the next state is STOP.
  - D>=2: the next state is DELAY, which loads the delay counter.
- DELAY: lasts D-1 cycles, then -> STOP.
- Timing rule: stop_o is asserted exactly D cycles after start_o.
- STOP (one cycle): stop_o=1.
  - If the pair index equals R: -> DONE.
  - Otherwise the index increments; -> GAP if G>0, else -> START directly.
- GAP: lasts G cycles, then -> START.
  - Timing rule: the next start_o is asserted exactly G+1 cycles after the previous stop_o.
- DONE (one cycle): done=1, busy=1, cfg_ready=0; -> IDLE.
  - cfg_ready returns to 1 two cycles after the final stop_o.
- Pair-index and counter widths:
  - The pair index counts 0..R with no wrap.
  - R = 2^CNT_W - 1 gives 2^CNT_W pairs.
  - The delay and gap counters are DLY_W bits; the maximum interval is 2^DLY_W - 1 cycles.
- abort:
  - Sampled at the rising edge. In any non-IDLE state it forces IDLE on that edge.
  - Any pulse already being output in the current cycle completes; no further start_o or stop_o follows.
  - done is not asserted; seq_idx clears to 0.
  - abort in IDLE has no effect. abort has priority over a simultaneous handshake, so the configuration is not accepted.
- Reset mid-sequence: outputs drop asynchronously to their reset values and the sequence is lost.

Decomposition:
- Shared package tdc_pkg:
  - state enum tdc_gen_state_t;
  - default DLY_W and CNT_W constants, shared with the TDC core so the measured-interval width matches.
- One sub-module, tdc_dly_counter:
  - loadable DLY_W-bit down-counter with a terminal-count flag;
  - instantiated once and reused for both the DELAY and GAP phases.

Test Plan:
- Reset, then D=5, G=2, R=0:
  - start_o at t0 and stop_o at t0+5;
  - done at t0+6 and cfg_ready=1 at t0+7;
  - exactly one pulse each.
- D=3, G=0, R=2:
  - start_o at t0, t0+4 and t0+8;
  - stop_o at t0+3, t0+7 and t0+11;
  - seq_idx steps 0,1,2; done at t0+12.
- D=0, G=1, R=1:
  - start_o and stop_o coincide at t0 and at t0+2;
  - done at t0+3.
- D=10, R=3, abort asserted at t0+4:
  - no stop_o occurs and done is never asserted;
  - busy=0 and cfg_ready=1 from t0+5.
- cfg_valid held high with changed D while busy:
  - the running sequence keeps the original D;
  - the new configuration is accepted only once the generator is back in IDLE.
- rst pulsed at t0+2 of a D=6 sequence:
  - all outputs are 0 immediately (asynchronously);
  - no stop_o follows after rst is released.
